mdu_ctrl: RTL and testbench

//  Sequencer between the EX stage and the shared iterative mul/div unit (MDU).

---
 rtl/mdu_ctrl_pkg.sv | 28 ++
 rtl/mdu_ctrl.sv | 130 +++++++++++++
 tb/tb_mdu_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the EX-stage mul/div sequencer: opcodes, MDU select codes and FSM states.
package mdu_ctrl_pkg;

    localparam logic [1:0] MDU_OP_MULT  = 2'b00;
    localparam logic [1:0] MDU_OP_MULTU = 2'b01;
    localparam logic [1:0] MDU_OP_DIV   = 2'b10;
    localparam logic [1:0] MDU_OP_DIVU  = 2'b11;

    localparam logic [1:0] MDU_SEL_IDLE = 2'b00;
    localparam logic [1:0] MDU_SEL_MUL  = 2'b01;
    localparam logic [1:0] MDU_SEL_DIV  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } mdu_state_t;

    function automatic logic [1:0] op_sel(input logic [1:0] op);
        return op[1] ? MDU_SEL_DIV : MDU_SEL_MUL;
    endfunction

    function automatic logic op_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Sequencer between EX and the shared iterative mul/div unit: start/annul handshake,
// pipeline stall, HI/LO write strobe, flush abort and watchdog abort.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DRAIN_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic [1:0]            req_op_i,
    input  logic [DATA_W-1:0]     rs_i,
    input  logic [DATA_W-1:0]     rt_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  hilo_we_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  timeout_o,
    output logic                  mdu_start_o,
    output logic                  mdu_annul_o,
    output logic                  mdu_signed_o,
    output logic [1:0]            mdu_sel_o,
    output logic [DATA_W-1:0]     mdu_op1_o,
    output logic [DATA_W-1:0]     mdu_op2_o,
    input  logic [2*DATA_W-1:0]   mdu_result_i,
    input  logic                  mdu_ready_i
);

    localparam logic [6:0] WDOG_LAST  = 7'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0] DRAIN_LAST = 7'(DRAIN_CYCLES - 1);

    mdu_state_t state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [1:0] sel_q;
    logic       signed_q;
    logic       accept;
    logic       capture;
    logic       wdog_fire;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 7'd1;
        accept    = 1'b0;
        capture   = 1'b0;
        wdog_fire = 1'b0;
        stall_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 7'd0;
                if (req_i && !flush_i) begin
                    accept  = 1'b1;
                    stall_o = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall_o = 1'b1;
                // flush outranks a simultaneous ready: the result is discarded
                if (flush_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = 7'd0;
                end else if (mdu_ready_i) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                    cnt_d   = 7'd0;
                end else if (cnt_q == WDOG_LAST) begin
                    wdog_fire = 1'b1;
                    state_d   = ST_DRAIN;
                    cnt_d     = 7'd0;
                end
            end
            ST_DONE: begin
                cnt_d   = 7'd0;
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = 7'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = 7'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decode directly from state so start and the write strobe never overlap
    assign busy_o       = (state_q != ST_IDLE);
    assign mdu_start_o  = (state_q == ST_BUSY);
    assign hilo_we_o    = (state_q == ST_DONE);
    assign mdu_annul_o  = (state_q == ST_DRAIN) && (cnt_q == 7'd0);
    assign mdu_sel_o    = busy_o ? sel_q : MDU_SEL_IDLE;
    assign mdu_signed_o = busy_o & signed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 7'd0;
            timeout_o <= 1'b0;
            sel_q     <= MDU_SEL_IDLE;
            signed_q  <= 1'b0;
            mdu_op1_o <= '0;
            mdu_op2_o <= '0;
            hi_o      <= '0;
            lo_o      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (wdog_fire) begin
                timeout_o <= 1'b1;
            end
            if (accept) begin
                sel_q     <= op_sel(req_op_i);
                signed_q  <= op_signed(req_op_i);
                mdu_op1_o <= rs_i;
                mdu_op2_o <= rt_i;
            end
            if (capture) begin
                {hi_o, lo_o} <= mdu_result_i;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl with a behavioural iterative MDU of programmable latency.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i = 1'b0;
    logic [1:0]  req_op_i = 2'b00;
    logic [31:0] rs_i = '0, rt_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o, busy_o, hilo_we_o, timeout_o;
    logic        mdu_start_o, mdu_annul_o, mdu_signed_o;
    logic [1:0]  mdu_sel_o;
    logic [31:0] hi_o, lo_o, mdu_op1_o, mdu_op2_o;
    logic [63:0] mdu_result;
    logic        mdu_ready;

    int n_cmp = 0;
    int n_err = 0;

    int mdu_cnt;
    int mdu_lat  = 4;
    bit mdu_dead = 1'b0;

    bit          chain_en = 1'b0;
    logic [1:0]  chain_op;
    logic [31:0] chain_a, chain_b;

    int          obs_we, obs_annul, obs_busy, obs_drain;
    bit          obs_viol, obs_stall_bad, obs_hang;
    logic        obs_first_stall;
    logic [31:0] obs_op1, obs_op2;
    logic [1:0]  obs_sel;
    logic        obs_sgn;
    logic [63:0] exp_hl = '0;

    mdu_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .req_op_i     (req_op_i),
        .rs_i         (rs_i),
        .rt_i         (rt_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .busy_o       (busy_o),
        .hilo_we_o    (hilo_we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .timeout_o    (timeout_o),
        .mdu_start_o  (mdu_start_o),
        .mdu_annul_o  (mdu_annul_o),
        .mdu_signed_o (mdu_signed_o),
        .mdu_sel_o    (mdu_sel_o),
        .mdu_op1_o    (mdu_op1_o),
        .mdu_op2_o    (mdu_op2_o),
        .mdu_result_i (mdu_result),
        .mdu_ready_i  (mdu_ready)
    );

    always #5 clk = ~clk;

    // Architectural result of a mul/div instruction: {hi, lo}
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub;
        logic signed [31:0] q, r;
        case (op)
            MDU_OP_MULT: begin
                sa = $signed(a);
                sb = $signed(b);
                return sa * sb;
            end
            MDU_OP_MULTU: begin
                ua = {32'd0, a};
                ub = {32'd0, b};
                return ua * ub;
            end
            MDU_OP_DIV: begin
                if (b == 32'd0) return 64'd0;
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return 64'd0;
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [63:0] mdu_compute(input logic [1:0] sel, input logic sgn,
                                                input logic [31:0] a, input logic [31:0] b);
        if (sel == 2'b10) return ref_model(sgn ? MDU_OP_DIV : MDU_OP_DIVU, a, b);
        if (sel == 2'b01) return ref_model(sgn ? MDU_OP_MULT : MDU_OP_MULTU, a, b);
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    // Iterative MDU: ready after mdu_lat+1 cycles of start, held until start drops
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdu_ready  <= 1'b0;
            mdu_cnt    <= 0;
            mdu_result <= '0;
        end else if (!mdu_start_o) begin
            mdu_ready <= 1'b0;
            mdu_cnt   <= 0;
        end else if (!mdu_ready) begin
            if (!mdu_dead && mdu_cnt >= mdu_lat) begin
                mdu_ready  <= 1'b1;
                mdu_result <= mdu_compute(mdu_sel_o, mdu_signed_o, mdu_op1_o, mdu_op2_o);
            end else begin
                mdu_cnt <= mdu_cnt + 1;
            end
        end
    end

    // Issues one instruction as EX would and records what the controller did with it
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int flush_at);
        bit fin, seen_start;
        obs_we = 0; obs_annul = 0; obs_busy = 0; obs_drain = 0;
        obs_viol = 0; obs_stall_bad = 0; obs_hang = 0;
        fin = 0; seen_start = 0;
        obs_op1 = '0; obs_op2 = '0; obs_sel = 2'b00; obs_sgn = 1'b0;
        if (!req_i) begin
            @(negedge clk);
            req_i = 1'b1; req_op_i = op; rs_i = a; rt_i = b;
            #1 obs_first_stall = stall_o;
        end else begin
            obs_first_stall = 1'b1;
        end
        for (int cyc = 1; cyc < 300 && !fin; cyc++) begin
            @(negedge clk);
            flush_i = 1'b0;
            if (mdu_start_o) begin
                obs_busy++;
                if (!seen_start) begin
                    seen_start = 1;
                    obs_op1 = mdu_op1_o; obs_op2 = mdu_op2_o; obs_sel = mdu_sel_o; obs_sgn = mdu_signed_o;
                end else if ({mdu_op1_o, mdu_op2_o, mdu_sel_o, mdu_signed_o} != {obs_op1, obs_op2, obs_sel, obs_sgn}) begin
                    obs_viol = 1;
                end
            end
            if (busy_o && !mdu_start_o && !hilo_we_o) obs_drain++;
            if (mdu_annul_o) begin
                obs_annul++;
                req_i = 1'b0;
            end
            if (hilo_we_o) begin
                obs_we++;
                if (mdu_start_o || stall_o) obs_viol = 1;
                if (chain_en) begin
                    req_op_i = chain_op; rs_i = chain_a; rt_i = chain_b;
                    fin = 1;
                end else begin
                    req_i = 1'b0;
                end
            end else if (req_i && !stall_o) begin
                obs_stall_bad = 1;
            end
            if (!busy_o) fin = 1;
            if (cyc == flush_at) begin
                flush_i = 1'b1;
                req_i   = 1'b0;
            end
        end
        if (!fin) obs_hang = 1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if ({busy_o, mdu_start_o, mdu_annul_o, hilo_we_o, timeout_o, stall_o, mdu_signed_o, mdu_sel_o} !== 9'd0) begin
            n_err++; $display("FAIL reset_ctrl: got %b expected 0", {busy_o, mdu_start_o, mdu_annul_o, hilo_we_o, timeout_o, stall_o, mdu_signed_o, mdu_sel_o}); end
        n_cmp++; if ({hi_o, lo_o, mdu_op1_o, mdu_op2_o} !== 128'd0) begin
            n_err++; $display("FAIL reset_data: got %h expected 0", {hi_o, lo_o, mdu_op1_o, mdu_op2_o}); end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({busy_o, mdu_start_o, mdu_annul_o, hilo_we_o, timeout_o, stall_o} !== 6'd0) begin
            n_err++; $display("FAIL reset_release: got %b expected 0", {busy_o, mdu_start_o, mdu_annul_o, hilo_we_o, timeout_o, stall_o}); end
    endtask

    task automatic test_divu();
        mdu_lat = 5;
        run_op(MDU_OP_DIVU, 32'd100, 32'd7, 0);
        n_cmp++; if ({hi_o, lo_o} !== {32'd2, 32'd14}) begin
            n_err++; $display("FAIL divu_result: got %h expected %h", {hi_o, lo_o}, {32'd2, 32'd14}); end
        n_cmp++; if (obs_we !== 1) begin n_err++; $display("FAIL divu_we_pulses: got %0d expected 1", obs_we); end
        n_cmp++; if ({obs_first_stall, obs_stall_bad, obs_viol, obs_hang} !== 4'b1000) begin
            n_err++; $display("FAIL divu_stall_start: got %b expected 1000", {obs_first_stall, obs_stall_bad, obs_viol, obs_hang}); end
        n_cmp++; if ({obs_op1, obs_op2, obs_sel, obs_sgn} !== {32'd100, 32'd7, 2'b10, 1'b0}) begin
            n_err++; $display("FAIL divu_mdu_if: got %h expected %h", {obs_op1, obs_op2, obs_sel, obs_sgn}, {32'd100, 32'd7, 2'b10, 1'b0}); end
        n_cmp++; if (obs_busy !== 7) begin n_err++; $display("FAIL divu_busy_cycles: got %0d expected 7", obs_busy); end
        exp_hl = {32'd2, 32'd14};
    endtask

    task automatic test_mult();
        mdu_lat = 3;
        run_op(MDU_OP_MULT, 32'hFFFF_FFFD, 32'd5, 0);
        n_cmp++; if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
            n_err++; $display("FAIL mult_result: got %h expected FFFFFFFFFFFFFFF1", {hi_o, lo_o}); end
        n_cmp++; if ({obs_sel, obs_sgn, obs_we[1:0]} !== 5'b01101) begin
            n_err++; $display("FAIL mult_sel_we: got %b expected 01101", {obs_sel, obs_sgn, obs_we[1:0]}); end
        mdu_lat = 33;
        run_op(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
        n_cmp++; if ({hi_o, lo_o} !== {32'd1, 32'hFFFF_FFFE}) begin
            n_err++; $display("FAIL multu_result: got %h expected 00000001FFFFFFFE", {hi_o, lo_o}); end
        n_cmp++; if ({obs_sel, obs_sgn, obs_viol, obs_stall_bad} !== 5'b01000) begin
            n_err++; $display("FAIL multu_sel_flags: got %b expected 01000", {obs_sel, obs_sgn, obs_viol, obs_stall_bad}); end
        exp_hl = {32'd1, 32'hFFFF_FFFE};
    endtask

    task automatic test_div_zero();
        mdu_lat = 10;
        run_op(MDU_OP_DIV, 32'd5, 32'd0, 0);
        n_cmp++; if ({hi_o, lo_o} !== 64'd0) begin n_err++; $display("FAIL divz_result: got %h expected 0", {hi_o, lo_o}); end
        n_cmp++; if ({obs_we[1:0], timeout_o, obs_sgn} !== 4'b0101) begin
            n_err++; $display("FAIL divz_we_timeout: got %b expected 0101", {obs_we[1:0], timeout_o, obs_sgn}); end
        exp_hl = 64'd0;
    endtask

    task automatic test_flush();
        mdu_lat = 30;
        exp_hl = 64'h1234_5678_9ABC_DEF0;
        run_op(MDU_OP_MULTU, 32'h1234_5678, 32'h1, 0);
        run_op(MDU_OP_DIV, 32'd1000, 32'd3, 10);
        n_cmp++; if ({obs_we, obs_annul, obs_busy, obs_drain} !== {32'd0, 32'd1, 32'd10, 32'd2}) begin
            n_err++; $display("FAIL flush_counts: we=%0d annul=%0d busy=%0d drain=%0d expected 0 1 10 2", obs_we, obs_annul, obs_busy, obs_drain); end
        n_cmp++; if ({hi_o, lo_o} !== 64'h0000_0000_1234_5678) begin
            n_err++; $display("FAIL flush_hilo_kept: got %h expected 0000000012345678", {hi_o, lo_o}); end
        mdu_lat = 2;
        run_op(MDU_OP_MULT, 32'd6, 32'd7, 0);
        n_cmp++; if ({hi_o, lo_o} !== 64'd42) begin n_err++; $display("FAIL flush_next_mult: got %h expected 42", {hi_o, lo_o}); end
        @(negedge clk);
        req_i = 1'b1; req_op_i = MDU_OP_DIV; rs_i = 32'd9; rt_i = 32'd3; flush_i = 1'b1;
        #1;
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL idle_flush_stall: got %b expected 0", stall_o); end
        @(negedge clk);
        n_cmp++; if ({busy_o, mdu_start_o} !== 2'b00) begin n_err++; $display("FAIL idle_flush_accept: got %b expected 00", {busy_o, mdu_start_o}); end
        req_i = 1'b0; flush_i = 1'b0;
        exp_hl = 64'd42;
    endtask

    task automatic test_back_to_back();
        logic [63:0] e1, e2;
        e1 = ref_model(MDU_OP_DIV, 32'hFFFF_FFB3, 32'd5);
        e2 = ref_model(MDU_OP_MULT, 32'd1234, 32'hFFFF_FFFE);
        chain_en = 1'b1; chain_op = MDU_OP_MULT; chain_a = 32'd1234; chain_b = 32'hFFFF_FFFE;
        mdu_lat = 8;
        run_op(MDU_OP_DIV, 32'hFFFF_FFB3, 32'd5, 0);
        chain_en = 1'b0;
        n_cmp++; if ({hi_o, lo_o} !== e1) begin n_err++; $display("FAIL b2b_div_result: got %h expected %h", {hi_o, lo_o}, e1); end
        n_cmp++; if ({mdu_start_o, hilo_we_o, stall_o} !== 3'b010) begin
            n_err++; $display("FAIL b2b_done_cycle: got %b expected 010", {mdu_start_o, hilo_we_o, stall_o}); end
        @(negedge clk);
        n_cmp++; if ({mdu_start_o, stall_o, busy_o} !== 3'b010) begin
            n_err++; $display("FAIL b2b_wait_cycle: got %b expected 010", {mdu_start_o, stall_o, busy_o}); end
        mdu_lat = 4;
        run_op(MDU_OP_MULT, 32'd1234, 32'hFFFF_FFFE, 0);
        n_cmp++; if ({hi_o, lo_o} !== e2) begin n_err++; $display("FAIL b2b_mult_result: got %h expected %h", {hi_o, lo_o}, e2); end
        n_cmp++; if ({obs_op1, obs_op2, obs_sel} !== {32'd1234, 32'hFFFF_FFFE, 2'b01}) begin
            n_err++; $display("FAIL b2b_mult_if: got %h expected %h", {obs_op1, obs_op2, obs_sel}, {32'd1234, 32'hFFFF_FFFE, 2'b01}); end
        exp_hl = e2;
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] e;
        int          fl;
        for (int i = 0; i < 16; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20));
            if (op[1] && $urandom_range(0, 7) == 0) b = 32'd0;
            if (op == MDU_OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            mdu_lat = $urandom_range(1, 36);
            fl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, mdu_lat + 1) : 0;
            e  = (fl != 0) ? exp_hl : ref_model(op, a, b);
            run_op(op, a, b, fl);
            n_cmp++; if ({hi_o, lo_o} !== e) begin n_err++; $display("FAIL rand_result[%0d]: got %h expected %h", i, {hi_o, lo_o}, e); end
            n_cmp++; if (obs_we !== ((fl != 0) ? 0 : 1) || obs_annul !== ((fl != 0) ? 1 : 0)) begin
                n_err++; $display("FAIL rand_we_annul[%0d]: got we=%0d annul=%0d flush_at=%0d", i, obs_we, obs_annul, fl); end
            n_cmp++; if (obs_busy !== ((fl != 0) ? fl : mdu_lat + 2)) begin
                n_err++; $display("FAIL rand_busy[%0d]: got %0d expected %0d", i, obs_busy, (fl != 0) ? fl : mdu_lat + 2); end
            n_cmp++; if ({obs_op1, obs_op2, obs_sel, obs_sgn} !== {a, b, op[1] ? 2'b10 : 2'b01, ~op[0]}) begin
                n_err++; $display("FAIL rand_mdu_if[%0d]: got %h expected %h", i, {obs_op1, obs_op2, obs_sel, obs_sgn}, {a, b, op[1] ? 2'b10 : 2'b01, ~op[0]}); end
            n_cmp++; if ({obs_viol, obs_stall_bad, obs_hang} !== 3'b000) begin
                n_err++; $display("FAIL rand_protocol[%0d]: got %b expected 000", i, {obs_viol, obs_stall_bad, obs_hang}); end
            exp_hl = e;
        end
    endtask

    task automatic test_timeout();
        mdu_dead = 1'b1;
        run_op(MDU_OP_DIVU, 32'd55, 32'd5, 0);
        mdu_dead = 1'b0;
        n_cmp++; if ({obs_busy, obs_annul, obs_we, obs_drain} !== {32'd64, 32'd1, 32'd0, 32'd2}) begin
            n_err++; $display("FAIL timeout_counts: busy=%0d annul=%0d we=%0d drain=%0d expected 64 1 0 2", obs_busy, obs_annul, obs_we, obs_drain); end
        n_cmp++; if ({timeout_o, busy_o, obs_hang} !== 3'b100) begin
            n_err++; $display("FAIL timeout_flag: got %b expected 100", {timeout_o, busy_o, obs_hang}); end
        n_cmp++; if ({hi_o, lo_o} !== exp_hl) begin n_err++; $display("FAIL timeout_hilo_kept: got %h expected %h", {hi_o, lo_o}, exp_hl); end
        mdu_lat = 6;
        run_op(MDU_OP_MULTU, 32'd3, 32'd4, 0);
        n_cmp++; if ({timeout_o, hi_o, lo_o} !== {1'b1, 64'd12}) begin
            n_err++; $display("FAIL timeout_sticky: got %h expected 1_000000000000000c", {timeout_o, hi_o, lo_o}); end
        exp_hl = 64'd12;
    endtask

    task automatic test_async_reset();
        mdu_lat = 30;
        @(negedge clk);
        req_i = 1'b1; req_op_i = MDU_OP_DIV; rs_i = 32'd500; rt_i = 32'd7;
        repeat (5) @(negedge clk);
        n_cmp++; if (mdu_start_o !== 1'b1) begin n_err++; $display("FAIL arst_midop_start: got %b expected 1", mdu_start_o); end
        req_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({busy_o, mdu_start_o, mdu_sel_o, timeout_o, hilo_we_o, hi_o, lo_o} !== 70'd0) begin
            n_err++; $display("FAIL arst_immediate: got %h expected 0", {busy_o, mdu_start_o, mdu_sel_o, timeout_o, hilo_we_o, hi_o, lo_o}); end
        @(negedge clk); rst = 1'b0;
        mdu_lat = 3;
        run_op(MDU_OP_MULTU, 32'd9, 32'd9, 0);
        n_cmp++; if ({timeout_o, hi_o, lo_o} !== {1'b0, 64'd81}) begin
            n_err++; $display("FAIL arst_recover: got %h expected 0_0000000000000051", {timeout_o, hi_o, lo_o}); end
    endtask

    initial begin
        #400000;
        n_err++;
        $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "bench time limit reached");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_divu();
        test_mult();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_random();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
